// File: rtl/rob_buffer_pkg.sv
// Shared widths, exception encoding and the per-entry payload layout for rob_buffer.
package rob_buffer_pkg;
  localparam int ROB_ADDR_WIDTH_DEF = 4;
  localparam int REG_ADDR_W         = 5;
  localparam int DATA_W             = 32;
  localparam int ADDR_W             = 32;
  localparam int EXC_TYPE_W         = 4;

  localparam logic [EXC_TYPE_W-1:0] EXC_TYPE_NULL = '0;

  typedef struct packed {
    logic                  reg_write_en;
    logic [REG_ADDR_W-1:0] reg_write_addr;
    logic [EXC_TYPE_W-1:0] exc_type;
    logic                  is_delayslot;
    logic [ADDR_W-1:0]     pc;
    logic [DATA_W-1:0]     data;
  } rob_entry_t;
endpackage

// File: rtl/rob_buffer.sv
// Circular reorder buffer: in-order allocate at tail, two writeback ports, in-order commit at head.
module rob_buffer
  import rob_buffer_pkg::*;
#(
  parameter int ROB_ADDR_WIDTH = ROB_ADDR_WIDTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,
  input  logic                      rob_write_en,
  output logic                      rob_can_write,
  output logic [ROB_ADDR_WIDTH-1:0] rob_write_addr,
  input  logic                      rob_write_reg_write_en,
  input  logic [REG_ADDR_W-1:0]     rob_write_reg_write_addr,
  input  logic [EXC_TYPE_W-1:0]     rob_write_exception_type,
  input  logic                      rob_write_is_delayslot,
  input  logic [ADDR_W-1:0]         rob_write_pc,
  input  logic                      wb0_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb0_addr,
  input  logic [DATA_W-1:0]         wb0_data,
  input  logic                      wb1_en,
  input  logic [ROB_ADDR_WIDTH-1:0] wb1_addr,
  input  logic [DATA_W-1:0]         wb1_data,
  input  logic                      rob_commit_en,
  output logic                      rob_can_commit,
  output logic                      rob_commit_reg_write_en,
  output logic [REG_ADDR_W-1:0]     rob_commit_reg_write_addr,
  output logic [DATA_W-1:0]         rob_commit_reg_write_data,
  output logic [EXC_TYPE_W-1:0]     rob_commit_exception_type,
  output logic                      rob_commit_is_delayslot,
  output logic [ADDR_W-1:0]         rob_commit_pc,
  input  logic [ROB_ADDR_WIDTH-1:0] read_addr,
  output logic                      read_done,
  output logic [DATA_W-1:0]         read_data
);
  localparam int DEPTH = 1 << ROB_ADDR_WIDTH;
  localparam logic [ROB_ADDR_WIDTH:0] DEPTH_C = {1'b1, {ROB_ADDR_WIDTH{1'b0}}};

  logic [ROB_ADDR_WIDTH-1:0] head, tail;
  logic [ROB_ADDR_WIDTH:0]   count;
  logic [DEPTH-1:0]          valid, done;
  rob_entry_t                ent [DEPTH];

  logic alloc, commit;

  assign rob_can_write  = (count != DEPTH_C);
  assign rob_write_addr = tail;
  assign rob_can_commit = valid[head] & done[head];
  assign alloc          = rob_write_en & rob_can_write;
  assign commit         = rob_commit_en & rob_can_commit;

  assign rob_commit_reg_write_en   = ent[head].reg_write_en;
  assign rob_commit_reg_write_addr = ent[head].reg_write_addr;
  assign rob_commit_reg_write_data = ent[head].data;
  assign rob_commit_exception_type = ent[head].exc_type;
  assign rob_commit_is_delayslot   = ent[head].is_delayslot;
  assign rob_commit_pc             = ent[head].pc;

  assign read_done = valid[read_addr] & done[read_addr];
  assign read_data = ent[read_addr].data;

  // Later assignments win: wb1 < wb0 < allocate < commit. Allocation only targets an
  // invalid slot, so a writeback to the same index was already gated off by valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else if (flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      valid <= '0;
      done  <= '0;
    end else begin
      if (wb1_en && valid[wb1_addr]) begin
        done[wb1_addr]     <= 1'b1;
        ent[wb1_addr].data <= wb1_data;
      end
      if (wb0_en && valid[wb0_addr]) begin
        done[wb0_addr]     <= 1'b1;
        ent[wb0_addr].data <= wb0_data;
      end
      if (alloc) begin
        ent[tail] <= '{reg_write_en:   rob_write_reg_write_en,
                       reg_write_addr: rob_write_reg_write_addr,
                       exc_type:       rob_write_exception_type,
                       is_delayslot:   rob_write_is_delayslot,
                       pc:             rob_write_pc,
                       data:           '0};
        valid[tail] <= 1'b1;
        done[tail]  <= (rob_write_exception_type != EXC_TYPE_NULL);
        tail        <= tail + 1'b1;
      end
      if (commit) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
        head        <= head + 1'b1;
      end
      case ({alloc, commit})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_rob_buffer.sv
// Directed bench for rob_buffer: vector table for the main flow, hand sequences for full/flush/reset.
module tb_rob_buffer;
  import rob_buffer_pkg::*;

  localparam int AW = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  rob_write_en;
  logic                  rob_can_write;
  logic [AW-1:0]         rob_write_addr;
  logic                  rob_write_reg_write_en;
  logic [REG_ADDR_W-1:0] rob_write_reg_write_addr;
  logic [EXC_TYPE_W-1:0] rob_write_exception_type;
  logic                  rob_write_is_delayslot;
  logic [ADDR_W-1:0]     rob_write_pc;
  logic                  wb0_en, wb1_en;
  logic [AW-1:0]         wb0_addr, wb1_addr;
  logic [DATA_W-1:0]     wb0_data, wb1_data;
  logic                  rob_commit_en;
  logic                  rob_can_commit;
  logic                  rob_commit_reg_write_en;
  logic [REG_ADDR_W-1:0] rob_commit_reg_write_addr;
  logic [DATA_W-1:0]     rob_commit_reg_write_data;
  logic [EXC_TYPE_W-1:0] rob_commit_exception_type;
  logic                  rob_commit_is_delayslot;
  logic [ADDR_W-1:0]     rob_commit_pc;
  logic [AW-1:0]         read_addr;
  logic                  read_done;
  logic [DATA_W-1:0]     read_data;

  rob_buffer #(.ROB_ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .rob_write_en(rob_write_en), .rob_can_write(rob_can_write), .rob_write_addr(rob_write_addr),
    .rob_write_reg_write_en(rob_write_reg_write_en), .rob_write_reg_write_addr(rob_write_reg_write_addr),
    .rob_write_exception_type(rob_write_exception_type), .rob_write_is_delayslot(rob_write_is_delayslot),
    .rob_write_pc(rob_write_pc),
    .wb0_en(wb0_en), .wb0_addr(wb0_addr), .wb0_data(wb0_data),
    .wb1_en(wb1_en), .wb1_addr(wb1_addr), .wb1_data(wb1_data),
    .rob_commit_en(rob_commit_en), .rob_can_commit(rob_can_commit),
    .rob_commit_reg_write_en(rob_commit_reg_write_en), .rob_commit_reg_write_addr(rob_commit_reg_write_addr),
    .rob_commit_reg_write_data(rob_commit_reg_write_data), .rob_commit_exception_type(rob_commit_exception_type),
    .rob_commit_is_delayslot(rob_commit_is_delayslot), .rob_commit_pc(rob_commit_pc),
    .read_addr(read_addr), .read_done(read_done), .read_data(read_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic                  we;
    logic [EXC_TYPE_W-1:0] exc;
    logic [ADDR_W-1:0]     pc;
    logic                  w0; logic [AW-1:0] a0; logic [DATA_W-1:0] d0;
    logic                  w1; logic [AW-1:0] a1; logic [DATA_W-1:0] d1;
    logic                  ce;
    logic [AW-1:0]         ra;
    logic                  e_cw; logic [AW-1:0] e_wa; logic e_cc;
    logic [DATA_W-1:0]     e_cdata; logic [EXC_TYPE_W-1:0] e_cexc;
    logic                  chk_rd; logic e_rdone; logic [DATA_W-1:0] e_rdata;
  } vec_t;

  vec_t vecs [$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle();
    flush = 0; rob_write_en = 0; rob_write_reg_write_en = 0; rob_write_reg_write_addr = '0;
    rob_write_exception_type = '0; rob_write_is_delayslot = 0; rob_write_pc = '0;
    wb0_en = 0; wb0_addr = '0; wb0_data = '0; wb1_en = 0; wb1_addr = '0; wb1_data = '0;
    rob_commit_en = 0; read_addr = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    idle(); rst = 0; #3; rst = 1; @(negedge clk);
  endtask

  task automatic alloc(input logic [EXC_TYPE_W-1:0] exc, input logic [ADDR_W-1:0] pc);
    rob_write_en = 1; rob_write_reg_write_en = 1; rob_write_reg_write_addr = 5'd7;
    rob_write_exception_type = exc; rob_write_pc = pc;
  endtask

  function automatic vec_t mk(input logic we, input logic [3:0] exc, input logic [31:0] pc,
      input logic w0, input logic [3:0] a0, input logic [31:0] d0,
      input logic w1, input logic [3:0] a1, input logic [31:0] d1,
      input logic ce, input logic [3:0] ra,
      input logic cw, input logic [3:0] wa, input logic cc, input logic [31:0] cd, input logic [3:0] cx,
      input logic chk, input logic rdn, input logic [31:0] rdd);
    vec_t v;
    v.we = we; v.exc = exc; v.pc = pc; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.w1 = w1; v.a1 = a1; v.d1 = d1; v.ce = ce; v.ra = ra;
    v.e_cw = cw; v.e_wa = wa; v.e_cc = cc; v.e_cdata = cd; v.e_cexc = cx;
    v.chk_rd = chk; v.e_rdone = rdn; v.e_rdata = rdd;
    return v;
  endfunction

  initial begin
    //          we exc pc     w0 a0 d0            w1 a1 d1     ce ra  cw wa cc cdata        cx chk rdn rdata
    vecs.push_back(mk(1, 0, 32'h100, 0, 0, 0,          0, 0, 0,     0, 0,  1, 1, 0, 0,           0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h104, 0, 0, 0,          0, 0, 0,     0, 0,  1, 2, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 1, 32'hDEADBEEF, 0, 0, 0,   0, 1,  1, 2, 0, 0,           0, 1, 1, 32'hDEADBEEF));
    vecs.push_back(mk(0, 0, 0,       1, 0, 32'h1234,   0, 0, 0,     0, 0,  1, 2, 1, 32'h1234,    0, 1, 1, 32'h1234));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          0, 0, 0,     1, 0,  1, 2, 1, 32'hDEADBEEF, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          0, 0, 0,     1, 0,  1, 2, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(1, 5, 32'h200, 0, 0, 0,          0, 0, 0,     0, 0,  1, 3, 1, 0,           5, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          0, 0, 0,     1, 0,  1, 3, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 3, 77,         0, 0, 0,     0, 3,  1, 3, 0, 0,           0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h300, 1, 3, 32'h55,     0, 0, 0,     0, 3,  1, 4, 0, 0,           0, 1, 0, 0));
    vecs.push_back(mk(1, 0, 32'h304, 1, 3, 5,          1, 3, 9,     0, 3,  1, 5, 1, 5,           0, 1, 1, 5));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          1, 4, 32'hAA, 1, 4, 1, 5, 1, 32'hAA,      0, 1, 1, 32'hAA));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          0, 0, 0,     1, 0,  1, 5, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 32'h400, 0, 0, 0,          0, 0, 0,     1, 0,  1, 6, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,       1, 5, 32'h99,     0, 0, 0,     0, 5,  1, 6, 1, 32'h99,      0, 1, 1, 32'h99));
    vecs.push_back(mk(0, 0, 0,       0, 0, 0,          0, 0, 0,     1, 0,  1, 6, 0, 0,           0, 0, 0, 0));

    idle(); rst = 0; #7;
    check("rst_can_write", 32'(rob_can_write), 1);
    check("rst_write_addr", 32'(rob_write_addr), 0);
    check("rst_can_commit", 32'(rob_can_commit), 0);
    check("rst_commit_data", rob_commit_reg_write_data, 0);
    check("rst_commit_pc", rob_commit_pc, 0);
    check("rst_read_done", 32'(read_done), 0);
    check("rst_read_data", read_data, 0);
    rst = 1; @(negedge clk);

    foreach (vecs[i]) begin
      vec_t v;
      v = vecs[i];
      idle();
      rob_write_en = v.we; rob_write_exception_type = v.exc; rob_write_pc = v.pc;
      wb0_en = v.w0; wb0_addr = v.a0; wb0_data = v.d0;
      wb1_en = v.w1; wb1_addr = v.a1; wb1_data = v.d1;
      rob_commit_en = v.ce; read_addr = v.ra;
      step();
      check($sformatf("v%0d_can_write", i), 32'(rob_can_write), 32'(v.e_cw));
      check($sformatf("v%0d_write_addr", i), 32'(rob_write_addr), 32'(v.e_wa));
      check($sformatf("v%0d_can_commit", i), 32'(rob_can_commit), 32'(v.e_cc));
      if (v.e_cc) begin
        check($sformatf("v%0d_commit_data", i), rob_commit_reg_write_data, v.e_cdata);
        check($sformatf("v%0d_commit_exc", i), 32'(rob_commit_exception_type), 32'(v.e_cexc));
      end
      if (v.chk_rd) begin
        check($sformatf("v%0d_read_done", i), 32'(read_done), 32'(v.e_rdone));
        check($sformatf("v%0d_read_data", i), read_data, v.e_rdata);
      end
    end

    // Fill to 16, overflow attempt, then commit+allocate while full.
    do_reset();
    for (int i = 0; i < 16; i++) begin
      check($sformatf("fill_addr%0d", i), 32'(rob_write_addr), i);
      idle(); alloc(0, 32'h1000 + 4 * i); step();
    end
    check("full_can_write", 32'(rob_can_write), 0);
    check("full_write_addr", 32'(rob_write_addr), 0);
    idle(); alloc(0, 32'hBAD); step();
    check("ovf_write_addr", 32'(rob_write_addr), 0);
    check("ovf_can_write", 32'(rob_can_write), 0);
    idle(); wb0_en = 1; wb0_addr = 0; wb0_data = 32'h42; step();
    check("full_head_commit", 32'(rob_can_commit), 1);
    check("full_head_pc", rob_commit_pc, 32'h1000);
    idle(); rob_commit_en = 1; alloc(0, 32'hBAD); step();
    check("cw_after_commit", 32'(rob_can_write), 1);
    check("wa_after_commit", 32'(rob_write_addr), 0);
    check("cc_after_commit", 32'(rob_can_commit), 0);
    idle(); alloc(0, 32'h2000); step();
    check("refill_can_write", 32'(rob_can_write), 0);
    check("refill_write_addr", 32'(rob_write_addr), 1);

    // Flush with eight in flight, alongside an allocate and a commit.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      idle(); alloc(4'd3, 32'h3000 + 4 * i); step();
    end
    check("pre_flush_addr", 32'(rob_write_addr), 8);
    check("pre_flush_cc", 32'(rob_can_commit), 1);
    idle(); alloc(4'd3, 32'hBAD); rob_commit_en = 1; flush = 1; step();
    check("flush_write_addr", 32'(rob_write_addr), 0);
    check("flush_can_commit", 32'(rob_can_commit), 0);
    check("flush_can_write", 32'(rob_can_write), 1);
    idle(); alloc(4'd2, 32'h4000); step();
    check("post_flush_cc", 32'(rob_can_commit), 1);
    check("post_flush_pc", rob_commit_pc, 32'h4000);
    check("post_flush_exc", 32'(rob_commit_exception_type), 2);

    // Asynchronous reset between clock edges.
    for (int i = 0; i < 3; i++) begin
      idle(); alloc(4'd1, 32'h5000 + 4 * i); step();
    end
    idle();
    @(negedge clk); #2;
    rst = 0; #1;
    check("arst_write_addr", 32'(rob_write_addr), 0);
    check("arst_can_commit", 32'(rob_can_commit), 0);
    check("arst_can_write", 32'(rob_can_write), 1);
    check("arst_commit_pc", rob_commit_pc, 0);
    #5; rst = 1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
